// File: rtl/pc_counter.sv
// Program counter: holds a WIDTH-bit fetch address with increment, jump load, and halt/resume/single-step control.
// Latency: one cycle. out and halted update on the edge that samples the inputs. There is no backpressure; inputs are sampled every edge.
// Optional: define PC_WRAP_FLAG_EN to add a registered one-cycle wrap pulse for all-ones -> 0 increments.
module pc_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             en,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             step,
    output logic [WIDTH-1:0] out,
`ifdef PC_WRAP_FLAG_EN
    output logic             wrap,
`endif
    output logic             halted
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic             inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            out   <= '0;
        end else begin
            state <= state_nxt;
            out   <= out_nxt;
        end
    end

    // load wins in both states. A state change never coincides with an increment.
    always_comb begin
        state_nxt = state;
        out_nxt   = out;
        inc       = 1'b0;
        case (state)
            RUN: begin
                if (load) begin
                    out_nxt = in;
                end else if (halt_req) begin
                    state_nxt = HALT;
                end else if (en) begin
                    inc = 1'b1;
                end
            end
            HALT: begin
                if (load) begin
                    out_nxt = in;
                end else if (resume) begin
                    state_nxt = RUN;
                end else if (step) begin
                    inc = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
        if (inc) begin
            out_nxt = out + 1'b1;
        end
    end

    assign halted = (state == HALT);

`ifdef PC_WRAP_FLAG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= inc && (out == {WIDTH{1'b1}});
        end
    end
`endif

endmodule
